// File: rtl/lvds_lane_align_ctrl.sv
// LVDS lane training: per-lane bitslip word alignment, then
// sync-marker deskew through each lane's variable shifter.
//
// Ports:
//   clk, reset       clk_rxg_x1 word clock, sync active-high reset
//   start            one-cycle training request (ignored while busy)
//   lane_data        12-bit word per lane, lane i at [12i+11:12i]
//   bitslip          per-lane bitslip request (2-cycle pulses)
//   shifter_addr     per-lane 4-bit shifter delay
//   align_en, busy   high while training is in progress
//   done, fail       sticky training result
//   lane_locked      per-lane word-lock status
module lvds_lane_align_ctrl #(
    parameter int          LANES      = 4,
    parameter logic [11:0] TRAIN_WORD = 12'h3A6,
    parameter logic [11:0] SYNC_WORD  = 12'hFC0,
    parameter int          SETTLE     = 16,
    parameter int          MATCH_CNT  = 8,
    parameter int          MAX_SLIP   = 24,
    parameter int          DESKEW_TO  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [12*LANES-1:0]  lane_data,
    output logic [LANES-1:0]     bitslip,
    output logic [4*LANES-1:0]   shifter_addr,
    output logic                 align_en,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [LANES-1:0]     lane_locked
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int MW = $clog2(MATCH_CNT + 1);
    localparam int PW = $clog2(MAX_SLIP + 1);

    typedef enum logic [2:0] {
        G_IDLE, G_WORD_ALIGN, G_DESKEW_CAP, G_APPLY,
        G_VERIFY, G_DONE, G_FAIL
    } gstate_t;

    typedef enum logic [2:0] {
        L_IDLE, L_SETTLE, L_CHECK, L_PULSE, L_LOCKED, L_FAIL
    } lstate_t;

    gstate_t            gst_q, gst_d;
    lstate_t            lst_q   [LANES];
    lstate_t            lst_d   [LANES];
    logic [SW-1:0]      scnt_q  [LANES];
    logic [SW-1:0]      scnt_d  [LANES];
    logic [MW-1:0]      mcnt_q  [LANES];
    logic [MW-1:0]      mcnt_d  [LANES];
    logic [PW-1:0]      slip_q  [LANES];
    logic [PW-1:0]      slip_d  [LANES];
    logic [7:0]         tcap_q  [LANES];
    logic [7:0]         tcap_d  [LANES];
    logic [7:0]         dlt     [LANES];
    logic [LANES-1:0]   tvld_q, tvld_d;
    logic [7:0]         timer_q, timer_d;
    logic [SW-1:0]      vcnt_q, vcnt_d;
    logic [4*LANES-1:0] shaddr_q, shaddr_d;
    logic [LANES-1:0]   locked_q, locked_d;
    logic [LANES-1:0]   bslip_q, bslip_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;

    logic [LANES-1:0]   train_hit, sync_hit;
    logic               any_fail, all_lock, too_far;
    logic [7:0]         tmax;

    always_comb begin
        gst_d    = gst_q;
        timer_d  = timer_q;
        vcnt_d   = vcnt_q;
        shaddr_d = shaddr_q;
        locked_d = locked_q;
        done_d   = done_q;
        fail_d   = fail_q;
        tvld_d   = tvld_q;
        any_fail = 1'b0;
        all_lock = 1'b1;
        too_far  = 1'b0;
        tmax     = '0;
        for (int i = 0; i < LANES; i++) begin
            lst_d[i]     = lst_q[i];
            scnt_d[i]    = scnt_q[i];
            mcnt_d[i]    = mcnt_q[i];
            slip_d[i]    = slip_q[i];
            tcap_d[i]    = tcap_q[i];
            dlt[i]       = '0;
            train_hit[i] = (lane_data[12*i +: 12] == TRAIN_WORD);
            sync_hit[i]  = (lane_data[12*i +: 12] == SYNC_WORD);
        end

        // Per-lane word-alignment FSMs only advance in WORD_ALIGN.
        if (gst_q == G_WORD_ALIGN) begin
            for (int i = 0; i < LANES; i++) begin
                unique case (lst_q[i])
                    L_SETTLE: begin
                        if (scnt_q[i] == SW'(SETTLE - 1)) begin
                            lst_d[i]  = L_CHECK;
                            scnt_d[i] = '0;
                        end else begin
                            scnt_d[i] = scnt_q[i] + 1'b1;
                        end
                    end
                    L_CHECK: begin
                        if (train_hit[i]) begin
                            if (mcnt_q[i] == MW'(MATCH_CNT - 1)) begin
                                lst_d[i]    = L_LOCKED;
                                locked_d[i] = 1'b1;
                            end
                            mcnt_d[i] = mcnt_q[i] + 1'b1;
                        end else begin
                            mcnt_d[i] = '0;
                            scnt_d[i] = '0;
                            if (slip_q[i] == PW'(MAX_SLIP))
                                lst_d[i] = L_FAIL;
                            else
                                lst_d[i] = L_PULSE;
                        end
                    end
                    L_PULSE: begin
                        // Two cycles high so the deserializer's edge
                        // detector sees exactly one rising edge.
                        if (scnt_q[i] == SW'(1)) begin
                            lst_d[i]  = L_SETTLE;
                            scnt_d[i] = '0;
                            slip_d[i] = slip_q[i] + 1'b1;
                        end else begin
                            scnt_d[i] = scnt_q[i] + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        for (int i = 0; i < LANES; i++) begin
            any_fail = any_fail | (lst_d[i] == L_FAIL);
            all_lock = all_lock & (lst_d[i] == L_LOCKED);
            if (tcap_q[i] > tmax)
                tmax = tcap_q[i];
        end
        for (int i = 0; i < LANES; i++) begin
            dlt[i] = tmax - tcap_q[i];
            if (dlt[i] > 8'd15)
                too_far = 1'b1;
        end

        unique case (gst_q)
            G_IDLE, G_DONE, G_FAIL: begin
                if (start) begin
                    gst_d    = G_WORD_ALIGN;
                    shaddr_d = '0;
                    locked_d = '0;
                    done_d   = 1'b0;
                    fail_d   = 1'b0;
                    tvld_d   = '0;
                    timer_d  = '0;
                    vcnt_d   = '0;
                    for (int i = 0; i < LANES; i++) begin
                        lst_d[i]  = L_SETTLE;
                        scnt_d[i] = '0;
                        mcnt_d[i] = '0;
                        slip_d[i] = '0;
                        tcap_d[i] = '0;
                    end
                end
            end
            G_WORD_ALIGN: begin
                // A failing lane wins over a simultaneous final lock.
                if (any_fail) begin
                    gst_d  = G_FAIL;
                    fail_d = 1'b1;
                end else if (all_lock) begin
                    gst_d   = G_DESKEW_CAP;
                    timer_d = '0;
                    tvld_d  = '0;
                end
            end
            G_DESKEW_CAP: begin
                for (int i = 0; i < LANES; i++) begin
                    if (!tvld_q[i] && sync_hit[i]) begin
                        tvld_d[i] = 1'b1;
                        tcap_d[i] = timer_q;
                    end
                end
                if (&tvld_d) begin
                    gst_d = G_APPLY;
                end else if (timer_q == 8'(DESKEW_TO)) begin
                    gst_d  = G_FAIL;
                    fail_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            G_APPLY: begin
                if (too_far) begin
                    gst_d  = G_FAIL;
                    fail_d = 1'b1;
                end else begin
                    for (int i = 0; i < LANES; i++)
                        shaddr_d[4*i +: 4] = dlt[i][3:0];
                    gst_d   = G_VERIFY;
                    vcnt_d  = '0;
                    timer_d = '0;
                end
            end
            G_VERIFY: begin
                if (vcnt_q != SW'(SETTLE)) begin
                    vcnt_d  = vcnt_q + 1'b1;
                    timer_d = '0;
                end else if (|sync_hit) begin
                    if (&sync_hit) begin
                        gst_d  = G_DONE;
                        done_d = 1'b1;
                    end else begin
                        gst_d  = G_FAIL;
                        fail_d = 1'b1;
                    end
                end else if (timer_q == 8'(DESKEW_TO)) begin
                    gst_d  = G_FAIL;
                    fail_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: gst_d = G_IDLE;
        endcase

        busy_d = (gst_d == G_WORD_ALIGN) || (gst_d == G_DESKEW_CAP) ||
                 (gst_d == G_APPLY) || (gst_d == G_VERIFY);
        for (int i = 0; i < LANES; i++)
            bslip_d[i] = (gst_d == G_WORD_ALIGN) && (lst_d[i] == L_PULSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gst_q    <= G_IDLE;
            timer_q  <= '0;
            vcnt_q   <= '0;
            shaddr_q <= '0;
            locked_q <= '0;
            tvld_q   <= '0;
            bslip_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lst_q[i]  <= L_IDLE;
                scnt_q[i] <= '0;
                mcnt_q[i] <= '0;
                slip_q[i] <= '0;
                tcap_q[i] <= '0;
            end
        end else begin
            gst_q    <= gst_d;
            timer_q  <= timer_d;
            vcnt_q   <= vcnt_d;
            shaddr_q <= shaddr_d;
            locked_q <= locked_d;
            tvld_q   <= tvld_d;
            bslip_q  <= bslip_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            for (int i = 0; i < LANES; i++) begin
                lst_q[i]  <= lst_d[i];
                scnt_q[i] <= scnt_d[i];
                mcnt_q[i] <= mcnt_d[i];
                slip_q[i] <= slip_d[i];
                tcap_q[i] <= tcap_d[i];
            end
        end
    end

    assign bitslip      = bslip_q;
    assign shifter_addr = shaddr_q;
    assign align_en     = busy_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fail         = fail_q;
    assign lane_locked  = locked_q;

endmodule

// File: tb/tb_lvds_lane_align_ctrl.sv
// Bench for lvds_lane_align_ctrl: a 4-lane deserializer model with
// bitslip rotation, marker skew and shifter delay, plus a scoreboard.
module tb_lvds_lane_align_ctrl;

    localparam logic [11:0] TW = 12'h3A6;
    localparam logic [11:0] SY = 12'hFC0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [47:0] lane_data = '0;
    logic [3:0]  bitslip;
    logic [15:0] shifter_addr;
    logic        align_en, busy, done, fail;
    logic [3:0]  lane_locked;

    lvds_lane_align_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .lane_data(lane_data), .bitslip(bitslip),
        .shifter_addr(shifter_addr), .align_en(align_en),
        .busy(busy), .done(done), .fail(fail),
        .lane_locked(lane_locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            done;
        logic            fail;
        logic [3:0]      locked;
        logic [15:0]     addr;
        logic [3:0][7:0] slips;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    // lane model configuration (written by tests, read by model)
    int offs[4];
    int skew[4];
    bit never[4];
    bit nomark[4];
    int snap[4];

    // model state (written only by the model process)
    int       cyc = 0;
    int       base = 0;
    bit       sync_on = 0;
    int       slip_cnt[4] = '{0, 0, 0, 0};
    logic [3:0] bs_prev = '0;

    function automatic logic [11:0] rotl(logic [11:0] w, int n);
        logic [23:0] t;
        int m;
        m = ((n % 12) + 12) % 12;
        t = {w, w} << m;
        return t[23:12];
    endfunction

    always @(negedge clk) begin
        int r;
        logic [11:0] w;
        cyc++;
        if (!busy)
            sync_on = 0;
        else if (!sync_on && lane_locked == 4'hF) begin
            sync_on = 1;
            base = cyc + 4;
        end
        for (int i = 0; i < 4; i++) begin
            if (bitslip[i] && !bs_prev[i])
                slip_cnt[i]++;
            bs_prev[i] = bitslip[i];
            r = cyc - int'(shifter_addr[4*i +: 4]) - skew[i];
            if (sync_on && !nomark[i] && r >= base && ((r - base) % 64) == 0)
                w = SY;
            else if (never[i])
                w = 12'h000;
            else
                w = rotl(TW, offs[i] + slip_cnt[i] - snap[i]);
            lane_data[12*i +: 12] = w;
        end
    end

    function automatic exp_t predict();
        exp_t e;
        int smax;
        e = '0;
        e.locked = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (never[i]) begin
                e.slips[i] = 8'd24;
                e.locked[i] = 1'b0;
                e.fail = 1'b1;
            end else begin
                e.slips[i] = 8'((12 - offs[i]) % 12);
            end
        end
        if (!e.fail) begin
            smax = 0;
            for (int i = 0; i < 4; i++) begin
                if (nomark[i]) e.fail = 1'b1;
                if (skew[i] > smax) smax = skew[i];
            end
            for (int i = 0; i < 4; i++) begin
                if (smax - skew[i] > 15) e.fail = 1'b1;
                e.addr[4*i +: 4] = 4'(smax - skew[i]);
            end
        end
        if (e.fail) e.addr = '0;
        e.done = !e.fail;
        return e;
    endfunction

    task automatic launch(input bit repulse, output bit to,
                          output int lock_k, output bit busy1);
        for (int i = 0; i < 4; i++) snap[i] = slip_cnt[i];
        sbq.push_back(predict());
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        lock_k = -1;
        to = 1'b1;
        for (int k = 1; k < 6000; k++) begin
            if (lock_k < 0 && lane_locked == 4'hF) lock_k = k - 1;
            if (done || fail) begin
                to = 1'b0;
                break;
            end
            start = (repulse && k == 60);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        sbq.push_back('0);
        repeat (3) @(negedge clk);
        e = sbq.pop_front();
        total++;
        if ({bitslip, shifter_addr, align_en, busy, done, fail, lane_locked}
            !== {4'h0, e.addr, 1'b0, 1'b0, e.done, e.fail, e.locked}) begin
            bad++;
            $display("FAIL reset_outs: got %h want 0",
                     {bitslip, shifter_addr, align_en, busy, done, fail, lane_locked});
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_aligned();
        bit to, b1;
        int lk;
        exp_t e;
        offs = '{0, 0, 0, 0}; skew = '{0, 0, 0, 0};
        never = '{0, 0, 0, 0}; nomark = '{0, 0, 0, 0};
        launch(1'b0, to, lk, b1);
        e = sbq.pop_front();
        total++;
        if (b1 !== 1'b1) begin
            bad++; $display("FAIL aligned_busy: got %b want 1", b1);
        end
        total++;
        if (lk !== 24) begin
            bad++; $display("FAIL aligned_lock_time: got %0d want 24", lk);
        end
        total++;
        if (to || done !== e.done || fail !== e.fail) begin
            bad++;
            $display("FAIL aligned_result: to=%b done=%b fail=%b want done=%b fail=%b",
                     to, done, fail, e.done, e.fail);
        end
        total++;
        if (shifter_addr !== e.addr || lane_locked !== e.locked || align_en !== 1'b0) begin
            bad++;
            $display("FAIL aligned_addr: addr=%h lock=%h en=%b want %h %h 0",
                     shifter_addr, lane_locked, align_en, e.addr, e.locked);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (slip_cnt[i] - snap[i] !== int'(e.slips[i])) begin
                bad++;
                $display("FAIL aligned_slips%0d: got %0d want %0d",
                         i, slip_cnt[i] - snap[i], e.slips[i]);
            end
        end
        repeat (20) @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL done_sticky: done=%b busy=%b want 1 0", done, busy);
        end
    endtask

    task automatic test_rotation();
        bit to, b1;
        int lk;
        exp_t e;
        offs = '{0, 3, 7, 11}; skew = '{0, 0, 0, 0};
        never = '{0, 0, 0, 0}; nomark = '{0, 0, 0, 0};
        launch(1'b1, to, lk, b1);
        e = sbq.pop_front();
        total++;
        if (to || done !== e.done || fail !== e.fail || lane_locked !== e.locked) begin
            bad++;
            $display("FAIL rotation_result: to=%b done=%b fail=%b lock=%h want %b %b %h",
                     to, done, fail, lane_locked, e.done, e.fail, e.locked);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (slip_cnt[i] - snap[i] !== int'(e.slips[i])) begin
                bad++;
                $display("FAIL rotation_slips%0d: got %0d want %0d",
                         i, slip_cnt[i] - snap[i], e.slips[i]);
            end
        end
    endtask

    task automatic test_skew();
        bit to, b1;
        int lk;
        exp_t e;
        offs = '{0, 0, 0, 0}; skew = '{0, 2, 5, 9};
        never = '{0, 0, 0, 0}; nomark = '{0, 0, 0, 0};
        launch(1'b0, to, lk, b1);
        e = sbq.pop_front();
        total++;
        if (to || done !== e.done || fail !== e.fail) begin
            bad++;
            $display("FAIL skew_result: to=%b done=%b fail=%b want %b %b",
                     to, done, fail, e.done, e.fail);
        end
        total++;
        if (shifter_addr !== e.addr) begin
            bad++;
            $display("FAIL skew_addr: got %h want %h", shifter_addr, e.addr);
        end
    endtask

    task automatic test_never();
        bit to, b1;
        int lk;
        exp_t e;
        offs = '{0, 0, 0, 0}; skew = '{0, 0, 0, 0};
        never = '{0, 0, 1, 0}; nomark = '{0, 0, 0, 0};
        launch(1'b0, to, lk, b1);
        e = sbq.pop_front();
        total++;
        if (to || done !== e.done || fail !== e.fail || lane_locked !== e.locked) begin
            bad++;
            $display("FAIL never_result: to=%b done=%b fail=%b lock=%h want %b %b %h",
                     to, done, fail, lane_locked, e.done, e.fail, e.locked);
        end
        total++;
        if (shifter_addr !== e.addr) begin
            bad++; $display("FAIL never_addr: got %h want %h", shifter_addr, e.addr);
        end
        total++;
        if (slip_cnt[2] - snap[2] !== int'(e.slips[2])) begin
            bad++;
            $display("FAIL never_slips: got %0d want %0d", slip_cnt[2] - snap[2], e.slips[2]);
        end
    endtask

    task automatic test_excess_skew();
        bit to, b1;
        int lk;
        exp_t e;
        offs = '{0, 0, 0, 0}; skew = '{0, 0, 0, 20};
        never = '{0, 0, 0, 0}; nomark = '{0, 0, 0, 0};
        launch(1'b0, to, lk, b1);
        e = sbq.pop_front();
        total++;
        if (to || done !== e.done || fail !== e.fail || shifter_addr !== e.addr) begin
            bad++;
            $display("FAIL excess_skew: to=%b done=%b fail=%b addr=%h want %b %b %h",
                     to, done, fail, shifter_addr, e.done, e.fail, e.addr);
        end
    endtask

    task automatic test_missing_marker();
        bit to, b1;
        int lk;
        exp_t e;
        offs = '{0, 0, 0, 0}; skew = '{0, 0, 0, 0};
        never = '{0, 0, 0, 0}; nomark = '{0, 1, 0, 0};
        launch(1'b0, to, lk, b1);
        e = sbq.pop_front();
        total++;
        if (to || done !== e.done || fail !== e.fail || lane_locked !== e.locked) begin
            bad++;
            $display("FAIL missing_marker: to=%b done=%b fail=%b lock=%h want %b %b %h",
                     to, done, fail, lane_locked, e.done, e.fail, e.locked);
        end
    endtask

    task automatic test_reset_mid_pulse();
        exp_t e;
        bit seen;
        offs = '{0, 3, 7, 11}; skew = '{0, 0, 0, 0};
        never = '{0, 0, 0, 0}; nomark = '{0, 0, 0, 0};
        for (int i = 0; i < 4; i++) snap[i] = slip_cnt[i];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (bitslip != 4'h0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL pulse_wait: got no bitslip want pulse");
        end
        reset = 1'b1;
        sbq.push_back('0);
        @(negedge clk);
        e = sbq.pop_front();
        total++;
        if ({bitslip, shifter_addr, align_en, busy, done, fail, lane_locked}
            !== {4'h0, e.addr, 1'b0, 1'b0, e.done, e.fail, e.locked}) begin
            bad++;
            $display("FAIL reset_mid_pulse: got %h want 0",
                     {bitslip, shifter_addr, align_en, busy, done, fail, lane_locked});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        offs = '{0, 0, 0, 0}; skew = '{0, 0, 0, 0};
        never = '{0, 0, 0, 0}; nomark = '{0, 0, 0, 0};
        snap = '{0, 0, 0, 0};
        @(negedge clk);
        test_reset();
        test_aligned();
        test_rotation();
        test_skew();
        test_never();
        test_excess_skew();
        test_missing_marker();
        test_reset_mid_pulse();
        test_aligned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lvds_lane_align_ctrl.md
# lvds_lane_align_ctrl

Training controller for the LVDS sensor receive path. It drives the per-lane `bitslip` and `shifter_addr` controls of the 1:12 deserializer lanes and watches their 12-bit parallel words. Word alignment comes first: each lane is bitslipped until it shows the training word. Inter-lane deskew follows: the controller times a sync-word marker on every lane and programs each lane's variable shifter so the markers line up. It sits between the sensor configuration sequencer (`start`, status) and the per-lane deserializer instances, in the `clk_rxg_x1` domain.

## Interface
- `LANES`, 4: number of deserializer lanes controlled.
- `TRAIN_WORD`, 12'h3A6: word-alignment training pattern.
- `SYNC_WORD`, 12'hFC0: deskew marker word.
- `SETTLE`, 16: cycles to wait after any bitslip or shifter change before sampling.
- `MATCH_CNT`, 8: consecutive matching words needed to lock a lane.
- `MAX_SLIP`, 24: bitslip attempts per lane before the lane fails (covers two full 12-bit rotations).
- `DESKEW_TO`, 255: marker capture and verify timeout, in cycles.
- `clk` in, 1: `clk_rxg_x1` parallel word clock.
- `reset` in, 1: reset, synchronous, active-high.
- `start` in, 1: one-cycle request to begin training.
- `lane_data` in, 12*LANES: lane i word at bits [12i+11:12i].
- `bitslip` out, LANES: per-lane bitslip request.
- `shifter_addr` out, 4*LANES: per-lane shifter delay.
- `align_en` out, 1: phase-detector alignment enable to the deserializers.
- `busy` out, 1: training in progress.
- `done` out, 1: training succeeded.
- `fail` out, 1: training failed.
- `lane_locked` out, LANES: per-lane word-lock status.

## Operation
- Global states: IDLE, WORD_ALIGN, DESKEW_CAP, APPLY, VERIFY, DONE, FAIL.
- IDLE/DONE/FAIL, `start`=1:
  - clear `shifter_addr`, `lane_locked`, `done`, `fail` and all lane counters;
  - go to WORD_ALIGN.
- `start` is ignored while `busy`.
- `busy`=1 and `align_en`=1 in WORD_ALIGN, DESKEW_CAP, APPLY and VERIFY; both are 0 otherwise.
- WORD_ALIGN runs one independent FSM per lane:
  - **L_SETTLE**: wait `SETTLE` cycles, then go to L_CHECK.
  - **L_CHECK**:
    - each word equal to `TRAIN_WORD` increments the match count;
    - when the count reaches `MATCH_CNT`, go to L_LOCKED and set `lane_locked[i]`=1;
    - any mismatch clears the count. If the slip count equals `MAX_SLIP`, go to L_FAIL; otherwise go to L_PULSE.
  - **L_PULSE**: drive `bitslip[i]`=1 for 2 cycles, increment the slip count, go to L_SETTLE. The deserializer edge-detects the pulse, so one pulse equals exactly one slip.
  - **L_LOCKED**: hold, no further checking.
  - **L_FAIL**: terminal.
- Global transitions out of WORD_ALIGN:
  - any lane in L_FAIL goes to FAIL, even if another lane locks in the same cycle;
  - all lanes in L_LOCKED goes to DESKEW_CAP.
- DESKEW_CAP:
  - an 8-bit timer starts at 0 on entry;
  - on the first cycle that lane i shows `SYNC_WORD`, record t_i (later occurrences are ignored);
  - once all lanes are recorded, go to APPLY;
  - timer reaching `DESKEW_TO` goes to FAIL.
- APPLY (1 cycle):
  - d_i = max(t) − t_i, computed in 8-bit unsigned arithmetic;
  - any d_i > 15 goes to FAIL;
  - otherwise `shifter_addr[i]` = d_i[3:0], then go to VERIFY.
- VERIFY:
  - wait `SETTLE` cycles, then restart the timer;
  - the first cycle in which any lane shows `SYNC_WORD` must show it on all lanes, which goes to DONE;
  - a partial set goes to FAIL;
  - timeout goes to FAIL.
- DONE and FAIL are sticky until `start` or `reset`.
- `shifter_addr` holds its value in DONE and FAIL.

## Timing
- Reset values: `bitslip`=0, `shifter_addr`=0, `align_en`=0, `busy`=0, `done`=0, `fail`=0, `lane_locked`=0. All FSMs and counters go to IDLE/0.
- `reset` asserted mid-training forces the reset values on the next edge. `bitslip` may be cut to a 1-cycle pulse.
- All outputs are registered.
- `start` at edge n gives `busy`=1 at n+1.
- Minimum lock time for an already-aligned lane is `SETTLE` + `MATCH_CNT` cycles after WORD_ALIGN entry.
- Each slip costs 2 + `SETTLE` + (mismatch position + 1) cycles.
- `bitslip` pulses are 2 cycles high and at least `SETTLE` cycles low between pulses.
- `done`/`fail` rise exactly 1 cycle after the deciding word is sampled. `busy` falls in the same cycle.
- Simultaneous marker detection on several lanes in one cycle gives equal t_i, hence d_i = 0 for those lanes.

## Test plan
- **All lanes already aligned** (all lanes constant `TRAIN_WORD`, sync marker every 64 cycles, skew 0): no `bitslip` pulses; `lane_locked`=4'hF after 24 cycles; all `shifter_addr` = 0; `done`=1; `fail`=0.
- **Per-lane rotation**: lane model rotates left by its slip count; lanes 0–3 initially offset 0, 3, 7, 11 → exactly 0, 9, 5, 1 pulses respectively (lane i needs (12 − offset) mod 12); all lock; `done`=1.
- **Skewed marker**: marker arrival skews of 0, 2, 5, 9 cycles on lanes 0–3 → `shifter_addr` = {9, 7, 4, 0} for lanes 0–3; VERIFY sees coincident markers; `done`=1.
- **Never matches**: lane 2 never shows `TRAIN_WORD` → 24 pulses on `bitslip[2]`, then `fail`=1 with `lane_locked[2]`=0; `shifter_addr` stays 0.
- **Excess skew / missing marker**: lane skew of 20 cycles → FAIL in APPLY. No marker on lane 1 → `fail`=1 at timer 255.
- **Reset and busy-ignore**: `reset` during a `bitslip` pulse → all outputs return to reset values next cycle. `start` re-pulsed while `busy` → ignored, pulse counts unchanged.
